// File: rtl/cpu_pkg.sv
// Shared datapath definitions: address width, reset vector and address type.
package cpu_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam logic [ADDR_WIDTH-1:0] PC_RESET_VECTOR = 16'h0000;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage : cpu_pkg

// File: rtl/en_reg.sv
// Generic WIDTH-bit register with load enable and async active-low reset.
// The register file uses this same cell.
module en_reg #(
    parameter int              WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset forces RESET_VALUE at once; otherwise capture d when enabled, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : en_reg

// File: rtl/program_counter.sv
// Program-counter register. Next-PC selection and incrementing happen
// upstream; this block only captures the chosen address on store.
module program_counter
    import cpu_pkg::*;
#(
    parameter int               WIDTH       = ADDR_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = PC_RESET_VECTOR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             store,
    output logic [WIDTH-1:0] out
);

    // Single enable register; out is driven straight from its flops.
    en_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst),
        .en    (store),
        .d     (in),
        .q     (out)
    );

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed and randomised checks of the program-counter register.
module tb_program_counter;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] in;
    logic        store;
    logic [15:0] out;

    int errors = 0;
    int checks = 0;

    program_counter #(
        .WIDTH       (16),
        .RESET_VALUE (16'h0000)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .store (store),
        .out   (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] expected);
        checks++;
        assert (out === expected)
        else begin
            errors++;
            $error("FAIL %s: out=%h expected=%h", tag, out, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] model;
    logic [15:0] rnd_in;
    logic        rnd_st;

    initial begin
        rst   = 1'b0;
        in    = 16'd15;
        store = 1'b0;

        // Reset takes effect before any clock edge.
        #2;
        check("reset_immediate", 16'h0000);
        step();
        check("reset_edge1", 16'h0000);
        store = 1'b1;
        step();
        check("reset_dominates_store", 16'h0000);

        // Release and first load.
        rst   = 1'b1;
        store = 1'b1;
        in    = 16'd15;
        step();
        check("first_load", 16'd15);

        // Hold while store is low, regardless of in.
        store = 1'b0;
        in    = 16'd17;
        step();
        check("hold_in17", 16'd15);
        in = 16'd21;
        step();
        check("hold_in21", 16'd15);
        step();
        check("hold_again", 16'd15);

        // Loads including all-ones.
        store = 1'b1;
        in    = 16'd21;
        step();
        check("load_21", 16'd21);
        in = 16'hFFFF;
        step();
        check("load_ffff", 16'hFFFF);
        store = 1'b0;
        in    = 16'h0000;
        step();
        check("hold_ffff", 16'hFFFF);
        store = 1'b1;
        in    = 16'd21;
        step();
        check("reload_21", 16'd21);

        // Mid-cycle reset overrides a pending load.
        in = 16'd5;
        #3;
        rst = 1'b0;
        #1;
        check("midcycle_reset", 16'h0000);
        step();
        check("reset_held_edge", 16'h0000);
        rst = 1'b1;
        in  = 16'h1234;
        step();
        check("load_after_reset", 16'h1234);

        // Random load/hold against a reference model.
        model = 16'h1234;
        for (int i = 0; i < 100; i++) begin
            rnd_in = 16'($urandom);
            rnd_st = 1'($urandom_range(0, 1));
            in     = rnd_in;
            store  = rnd_st;
            step();
            if (rnd_st) model = rnd_in;
            check("random", model);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_program_counter
